bch_31_decoder: RTL and testbench
=================================

Name: bch_31_decoder

Overview:
- Error-correction stage placed directly downstream of bch_31_syndrome in the BCH(31,21), t=2 receive path.
- Accepts a received 31-bit word together with its syndromes S1..S4 over GF(2^5), using primitive polynomial x^5+x^2+1.
- Solves the error-locator polynomial with the closed-form Peterson solution for t=2, then runs a serial Chien search at one position per clock.
- Outputs the corrected codeword, the extracted 21-bit message and error status, using a valid/ready handshake on both sides.

Parameters:
- N, 31, codeword length; fixed, not overridable.
- K, 21, message length; message occupies codeword[30:10].
- M, 5, GF(2^m) symbol width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  codeword and S1..S4 are valid
- in_ready  output  1  block can accept a word (high only in IDLE)
- codeword  input  31  received word; bit i is the coefficient of x^i
- S1, S2, S3, S4  input  5 each  syndromes, polynomial basis
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- corrected  output  31  corrected word (equals input word if uncorrectable)
- msg_out  output  21  corrected[30:10]
- err_count  output  2  number of bits corrected (0, 1 or 2)
- uncorrectable  output  1  decode failure flag

Behaviour:
- Reset:
  - state=IDLE; in_ready=1; out_valid=0.
  - corrected=0; err_count=0; uncorrectable=0.
  - Internal registers σ1, σ2, i counter and root counter are cleared.
  - Reset mid-operation aborts the current word; no result is produced.
- IDLE:
  - in_ready=1.
  - On in_valid: register codeword and S1..S4, then go to SOLVE.
- SOLVE (1 cycle):
  - All S = 0: no error; err_count=0; go to DONE.
  - S2≠S1² or S4≠S2²: uncorrectable; go to DONE.
  - S1=0 and S3≠0: uncorrectable; go to DONE.
  - Otherwise: σ1=S1; σ2=(S3+S1³)·S1⁻¹. Expected degree = 2 if σ2≠0, else 1. Go to CHIEN.
  - GF inverse is a 31-entry lookup; the multiplier is combinational mod x^5+x^2+1.
- CHIEN (exactly 31 cycles, i = 0..30):
  - Registers t1, t2 load σ1, σ2 at entry.
  - Each cycle test 1+t1+t2 == 0. If zero, flip bit i of the working word and increment the root count.
  - Then t1 ← t1·α⁻¹ and t2 ← t2·α⁻².
  - After i=30: if root count ≠ expected degree, set uncorrectable=1, restore the original codeword and set err_count=0. Otherwise err_count = root count.
  - Go to DONE.
- DONE:
  - out_valid=1; outputs stable while out_valid && !out_ready.
  - out_valid && out_ready: go to IDLE. in_ready rises the next cycle; there is no overlap of input and output.
- Latency, with the input accepted at edge k:
  - Nonzero-syndrome word: out_valid from cycle k+33.
  - All-zero-syndrome word or early-uncorrectable word: out_valid from cycle k+2.
- in_valid outside IDLE is ignored; upstream must hold the data until in_ready.
- out_ready held high: one word per 34 cycles (3 for zero-syndrome words).

Test Plan:
- Clean word: msg=21'h000001, encoder output applied with its syndromes (all 0) -> corrected = input word, msg_out=21'h000001, err_count=0, uncorrectable=0, out_valid at k+2.
- Single error: same codeword with bit 5 flipped -> corrected = clean codeword, err_count=1, uncorrectable=0, out_valid at k+33.
- Double error: msg=21'h15A5A5 codeword with bits 0 and 30 flipped (the wrap-around ends of the Chien search) -> clean codeword restored, err_count=2.
- Triple error: flip bits 3, 12 and 27 -> either uncorrectable=1 with corrected = received word and err_count=0, or a wrong but valid codeword. The bench checks the flag against a reference model.
- Inconsistent syndromes: S1=5'h01, S2=5'h03 -> uncorrectable=1 at k+2.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout.
  - Assert rst at cycle k+15 of a CHIEN run -> the next cycle shows in_ready=1 and out_valid=0, and no stale result is emitted.

Source files
------------

// File: rtl/bch_31_decoder_if.sv
// Handshake and data bundle between a BCH(31,21) syndrome stage, the
// decoder and the downstream consumer. Signal names follow the decoder's
// published port list; master drives the inputs, slave is the decoder.
interface bch_31_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] codeword;
  logic [4:0]  S1;
  logic [4:0]  S2;
  logic [4:0]  S3;
  logic [4:0]  S4;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] corrected;
  logic [20:0] msg_out;
  logic [1:0]  err_count;
  logic        uncorrectable;

  modport master (
    output in_valid, codeword, S1, S2, S3, S4, out_ready,
    input  in_ready, out_valid, corrected, msg_out, err_count, uncorrectable
  );

  modport slave (
    input  in_valid, codeword, S1, S2, S3, S4, out_ready,
    output in_ready, out_valid, corrected, msg_out, err_count, uncorrectable
  );
endinterface

// File: rtl/bch_31_decoder.sv
// BCH(31,21) t=2 decoder: closed-form Peterson solve of the error locator
// over GF(2^5) (x^5+x^2+1), then a serial Chien search, one bit per clock.
module bch_31_decoder (
  input logic             clk,
  input logic             rst,
  bch_31_decoder_if.slave bus
);
  localparam int N = 31;
  localparam int K = 21;
  localparam int M = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_SOLVE, ST_CHIEN, ST_DONE} state_t;

  // Polynomial-basis multiply, reducing by x^5 = x^2 + 1 at every shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = 5'h00;
    sh  = a;
    for (int k = 0; k < M; k++) begin
      if (b[k]) acc = acc ^ sh;
      else      acc = acc;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? 5'h05 : 5'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse table; zero has no inverse and maps to zero.
  function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
    case (a)
      5'h01: gf_inv = 5'h01;  5'h02: gf_inv = 5'h12;  5'h03: gf_inv = 5'h1C;
      5'h04: gf_inv = 5'h09;  5'h05: gf_inv = 5'h17;  5'h06: gf_inv = 5'h0E;
      5'h07: gf_inv = 5'h0C;  5'h08: gf_inv = 5'h16;  5'h09: gf_inv = 5'h04;
      5'h0A: gf_inv = 5'h19;  5'h0B: gf_inv = 5'h10;  5'h0C: gf_inv = 5'h07;
      5'h0D: gf_inv = 5'h0F;  5'h0E: gf_inv = 5'h06;  5'h0F: gf_inv = 5'h0D;
      5'h10: gf_inv = 5'h0B;  5'h11: gf_inv = 5'h18;  5'h12: gf_inv = 5'h02;
      5'h13: gf_inv = 5'h1D;  5'h14: gf_inv = 5'h1E;  5'h15: gf_inv = 5'h1A;
      5'h16: gf_inv = 5'h08;  5'h17: gf_inv = 5'h05;  5'h18: gf_inv = 5'h11;
      5'h19: gf_inv = 5'h0A;  5'h1A: gf_inv = 5'h15;  5'h1B: gf_inv = 5'h1F;
      5'h1C: gf_inv = 5'h03;  5'h1D: gf_inv = 5'h13;  5'h1E: gf_inv = 5'h14;
      5'h1F: gf_inv = 5'h1B;
      default: gf_inv = 5'h00;
    endcase
  endfunction

  state_t         r_state, w_state_next;
  logic [N-1:0]   r_orig, w_orig_next;
  logic [N-1:0]   r_word, w_word_next;
  logic [M-1:0]   r_s1, r_s2, r_s3, r_s4;
  logic [M-1:0]   w_s1_next, w_s2_next, w_s3_next, w_s4_next;
  logic [M-1:0]   r_t1, r_t2, w_t1_next, w_t2_next;
  logic           r_deg2, w_deg2_next;
  logic [4:0]     r_idx, w_idx_next;
  logic [1:0]     r_roots, w_roots_next;
  logic [N-1:0]   r_corrected, w_corr_next;
  logic [1:0]     r_err, w_err_next;
  logic           r_unc, w_unc_next;
  logic           r_in_ready, r_out_valid;

  logic           w_s_zero, w_incons, w_root;
  logic [M-1:0]   w_sigma2;
  logic [N-1:0]   w_word_flip;
  logic [1:0]     w_roots_inc, w_expected;

  assign w_s_zero    = ((r_s1 | r_s2 | r_s3 | r_s4) == 5'h00);
  assign w_incons    = (r_s2 != gf_mul(r_s1, r_s1)) || (r_s4 != gf_mul(r_s2, r_s2));
  assign w_sigma2    = gf_mul(r_s3 ^ gf_mul(gf_mul(r_s1, r_s1), r_s1), gf_inv(r_s1));
  // sigma(alpha^-i) = 1 + t1 + t2 vanishes exactly when t1 ^ t2 == 1.
  assign w_root      = ((r_t1 ^ r_t2) == 5'h01);
  assign w_word_flip = r_word ^ (w_root ? (31'd1 << r_idx) : 31'd0);
  assign w_roots_inc = r_roots + {1'b0, w_root};
  assign w_expected  = r_deg2 ? 2'd2 : 2'd1;

  // Next-state and next-datapath decisions for the IDLE/SOLVE/CHIEN/DONE flow.
  always_comb begin
    w_state_next = r_state;
    w_orig_next  = r_orig;
    w_word_next  = r_word;
    w_s1_next    = r_s1;
    w_s2_next    = r_s2;
    w_s3_next    = r_s3;
    w_s4_next    = r_s4;
    w_t1_next    = r_t1;
    w_t2_next    = r_t2;
    w_deg2_next  = r_deg2;
    w_idx_next   = r_idx;
    w_roots_next = r_roots;
    w_corr_next  = r_corrected;
    w_err_next   = r_err;
    w_unc_next   = r_unc;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_orig_next  = bus.codeword;
          w_s1_next    = bus.S1;
          w_s2_next    = bus.S2;
          w_s3_next    = bus.S3;
          w_s4_next    = bus.S4;
          w_state_next = ST_SOLVE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SOLVE: begin
        w_corr_next = r_orig;
        w_err_next  = 2'd0;
        if (w_s_zero) begin
          w_unc_next   = 1'b0;
          w_state_next = ST_DONE;
        end else if (w_incons || ((r_s1 == 5'h00) && (r_s3 != 5'h00))) begin
          w_unc_next   = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_unc_next   = 1'b0;
          w_t1_next    = r_s1;
          w_t2_next    = w_sigma2;
          w_deg2_next  = (w_sigma2 != 5'h00);
          w_idx_next   = 5'd0;
          w_roots_next = 2'd0;
          w_word_next  = r_orig;
          w_state_next = ST_CHIEN;
        end
      end
      ST_CHIEN: begin
        w_word_next  = w_word_flip;
        w_roots_next = w_roots_inc;
        w_t1_next    = gf_mul(r_t1, 5'h12);  // alpha^-1
        w_t2_next    = gf_mul(r_t2, 5'h09);  // alpha^-2
        w_idx_next   = r_idx + 5'd1;
        if (r_idx == 5'd30) begin
          w_state_next = ST_DONE;
          if (w_roots_inc != w_expected) begin
            w_unc_next  = 1'b1;
            w_corr_next = r_orig;
            w_err_next  = 2'd0;
          end else begin
            w_unc_next  = 1'b0;
            w_corr_next = w_word_flip;
            w_err_next  = w_roots_inc;
          end
        end else begin
          w_state_next = ST_CHIEN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) w_state_next = ST_IDLE;
        else               w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_orig      <= 31'd0;
      r_word      <= 31'd0;
      r_s1        <= 5'h00;
      r_s2        <= 5'h00;
      r_s3        <= 5'h00;
      r_s4        <= 5'h00;
      r_t1        <= 5'h00;
      r_t2        <= 5'h00;
      r_deg2      <= 1'b0;
      r_idx       <= 5'd0;
      r_roots     <= 2'd0;
      r_corrected <= 31'd0;
      r_err       <= 2'd0;
      r_unc       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_orig      <= w_orig_next;
      r_word      <= w_word_next;
      r_s1        <= w_s1_next;
      r_s2        <= w_s2_next;
      r_s3        <= w_s3_next;
      r_s4        <= w_s4_next;
      r_t1        <= w_t1_next;
      r_t2        <= w_t2_next;
      r_deg2      <= w_deg2_next;
      r_idx       <= w_idx_next;
      r_roots     <= w_roots_next;
      r_corrected <= w_corr_next;
      r_err       <= w_err_next;
      r_unc       <= w_unc_next;
      r_in_ready  <= (w_state_next == ST_IDLE);
      r_out_valid <= (w_state_next == ST_DONE);
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.corrected     = r_corrected;
  assign bus.msg_out       = r_corrected[N-1:N-K];
  assign bus.err_count     = r_err;
  assign bus.uncorrectable = r_unc;
endmodule

// File: tb/tb_bch_31_decoder.sv
// Self-checking bench for bch_31_decoder: systematic encoder, syndrome
// calculator and a brute-force nearest-codeword reference, all built on
// log/antilog tables, compared against every result the DUT presents.
module tb_bch_31_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bch_31_decoder_if bus();
  bch_31_decoder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [30:0] corr;
    logic [1:0]  err;
    logic        unc;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   or_mode = 0;
  int   alog[0:30];
  int   glog[0:31];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [4:0] fmul(input logic [4:0] a, input logic [4:0] b);
    if (a == 5'h00 || b == 5'h00) return 5'h00;
    return 5'(alog[(glog[a] + glog[b]) % 31]);
  endfunction

  function automatic logic [4:0] syn(input logic [30:0] r, input int j);
    logic [4:0] s = 5'h00;
    for (int i = 0; i < 31; i++)
      if (r[i]) s = s ^ 5'(alog[(j * i) % 31]);
    return s;
  endfunction

  function automatic logic [30:0] encode(input logic [20:0] msg);
    logic [30:0] rem;
    logic [30:0] g = 31'h769;  // x^10+x^9+x^8+x^6+x^5+x^3+1
    rem = {msg, 10'd0};
    for (int b = 30; b >= 10; b--)
      if (rem[b]) rem = rem ^ (g << (b - 10));
    return {msg, rem[9:0]};
  endfunction

  // Reference decode: early exits from syndrome rules, otherwise search every
  // weight-1 and weight-2 error pattern for one that explains S1 and S3.
  task automatic model(input logic [30:0] r, input logic [4:0] s1, s2, s3, s4,
                       output logic [30:0] c, output logic [1:0] e, output logic u,
                       output int lat);
    c = r; e = 2'd0; u = 1'b0; lat = 1;
    if ((s1 | s2 | s3 | s4) == 5'h00) return;
    if (s2 != fmul(s1, s1) || s4 != fmul(s2, s2) || s1 == 5'h00) begin
      u = 1'b1;
      return;
    end
    lat = 32;
    for (int i = 0; i < 31; i++)
      if (5'(alog[i]) == s1 && 5'(alog[(3 * i) % 31]) == s3) begin
        c = r ^ (31'd1 << i); e = 2'd1; return;
      end
    for (int i = 0; i < 31; i++)
      for (int j = i + 1; j < 31; j++)
        if ((5'(alog[i]) ^ 5'(alog[j])) == s1 &&
            (5'(alog[(3 * i) % 31]) ^ 5'(alog[(3 * j) % 31])) == s3) begin
          c = r ^ (31'd1 << i) ^ (31'd1 << j); e = 2'd2; return;
        end
    u = 1'b1;
  endtask

  task automatic send(input logic [30:0] w, input logic [4:0] a, b, c, d);
    exp_t e;
    int   n = 0;
    logic r = 1'b0;
    model(w, a, b, c, d, e.corr, e.err, e.unc, e.lat);
    e.acc = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.codeword = w;
    bus.S1 = a; bus.S2 = b; bus.S3 = c; bus.S4 = d;
    while (!r && n < 200) begin
      @(negedge clk);
      r = bus.in_ready;
      e.acc = cyc + 1;
      @(posedge clk);
      n++;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.codeword = 31'($urandom);
    bus.S1 = 5'($urandom); bus.S2 = 5'($urandom);
    if (r) exp_q.push_back(e);
    else   fail("in_ready_timeout");
  endtask

  task automatic send_word(input logic [30:0] w);
    send(w, syn(w, 1), syn(w, 2), syn(w, 3), syn(w, 4));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("drain_timeout");
  endtask

  // Consumer-side ready: always, random, or held low.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: new results against the model, stalled results for stability.
  initial begin
    logic        prev_ov = 1'b0, prev_or = 1'b0;
    logic [30:0] h_corr = 31'd0;
    logic [1:0]  h_err = 2'd0;
    logic        h_unc = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0; prev_or = 1'b0;
      end else begin
        if (bus.out_valid) begin
          chk("in_ready_low_while_out_valid", {31'd0, bus.in_ready}, 32'd0);
          if (prev_ov && !prev_or) begin
            chk("stall_corrected", {1'b0, bus.corrected}, {1'b0, h_corr});
            chk("stall_err_count", {30'd0, bus.err_count}, {30'd0, h_err});
            chk("stall_uncorrectable", {31'd0, bus.uncorrectable}, {31'd0, h_unc});
          end else if (!prev_ov) begin
            if (exp_q.size() == 0) fail("unexpected_result");
            else begin
              e = exp_q.pop_front();
              chk("corrected", {1'b0, bus.corrected}, {1'b0, e.corr});
              chk("msg_out", {11'd0, bus.msg_out}, {11'd0, e.corr[30:10]});
              chk("err_count", {30'd0, bus.err_count}, {30'd0, e.err});
              chk("uncorrectable", {31'd0, bus.uncorrectable}, {31'd0, e.unc});
              chk("latency", cyc - e.acc, e.lat);
            end
          end else begin
            fail("out_valid_after_handshake");
          end
          h_corr = bus.corrected; h_err = bus.err_count; h_unc = bus.uncorrectable;
        end
        prev_ov = bus.out_valid;
        prev_or = bus.out_ready;
      end
    end
  end

  initial begin
    logic [30:0] cw1, cw2, r, pat, mc;
    logic [1:0]  me;
    logic        mu;
    int          ml, a, nerr, kind, n;
    logic [4:0]  s2x;

    a = 1;
    glog[0] = 0;
    for (int i = 0; i < 31; i++) begin
      alog[i] = a; glog[a] = i;
      a = a << 1;
      if (a >= 32) a = a ^ 37;
    end

    bus.in_valid = 1'b0; bus.codeword = 31'd0;
    bus.S1 = 5'h00; bus.S2 = 5'h00; bus.S3 = 5'h00; bus.S4 = 5'h00;

    // Hand-computed pins on the reference itself.
    cw1 = encode(21'h000001);
    cw2 = encode(21'h15A5A5);
    chk("pin_encode_msg1", {1'b0, cw1}, 32'h00000769);
    chk("pin_syndrome_clean", {27'd0, syn(cw1, 1) | syn(cw1, 3)}, 32'd0);
    chk("pin_s1_bit5", {27'd0, syn(cw1 ^ 31'h20, 1)}, 32'h05);
    chk("pin_s3_bit5", {27'd0, syn(cw1 ^ 31'h20, 3)}, 32'h1F);
    r = cw1 ^ 31'h20;
    model(r, syn(r, 1), syn(r, 2), syn(r, 3), syn(r, 4), mc, me, mu, ml);
    chk("pin_model_single", {1'b0, mc}, 32'h00000769);
    chk("pin_model_single_err", {30'd0, me}, 32'd1);
    chk("pin_model_single_lat", ml, 32);
    r = cw2 ^ 31'h40000001;
    model(r, syn(r, 1), syn(r, 2), syn(r, 3), syn(r, 4), mc, me, mu, ml);
    chk("pin_model_double", {1'b0, mc}, {1'b0, cw2});
    chk("pin_model_double_err", {30'd0, me}, 32'd2);
    model(cw1, 5'h01, 5'h03, 5'h00, 5'h00, mc, me, mu, ml);
    chk("pin_model_incons", {31'd0, mu}, 32'd1);
    chk("pin_model_incons_lat", ml, 1);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_corrected", {1'b0, bus.corrected}, 32'd0);
    chk("reset_err_count", {30'd0, bus.err_count}, 32'd0);
    chk("reset_uncorrectable", {31'd0, bus.uncorrectable}, 32'd0);

    // Directed words.
    send_word(cw1);
    send_word(cw1 ^ 31'h20);
    send_word(cw2 ^ 31'h40000001);
    send_word(cw2 ^ (31'd1 << 3) ^ (31'd1 << 12) ^ (31'd1 << 27));
    send(cw1, 5'h01, 5'h03, 5'h00, 5'h00);
    drain();

    // Consumer stall: outputs held and in_ready low for 10 cycles.
    or_mode = 2;
    send_word(cw2 ^ (31'd1 << 17));
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail("stall_out_valid_timeout");
    repeat (10) @(negedge clk);
    or_mode = 0;
    drain();

    // Reset in the middle of a Chien search.
    send_word(cw1 ^ (31'd1 << 9));
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (40) @(negedge clk);

    // Randomized words with random consumer back-pressure.
    or_mode = 1;
    for (int t = 0; t < 40; t++) begin
      cw2  = encode(21'($urandom));
      kind = $urandom_range(0, 9);
      nerr = (kind < 2) ? 0 : (kind < 5) ? 1 : (kind < 8) ? 2 : (kind == 8) ? 3 : 4;
      pat  = 31'd0;
      while ($countones(pat) < nerr) pat[$urandom_range(0, 30)] = 1'b1;
      r = cw2 ^ pat;
      if (kind == 9 && $urandom_range(0, 1) == 1) begin
        s2x = 5'($urandom_range(1, 31));
        send(r, syn(r, 1), syn(r, 2) ^ s2x, syn(r, 3), syn(r, 4));
      end else begin
        send_word(r);
      end
    end
    or_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
